// File: rtl/wb_cmd_master_if.sv
// wb_cmd_master_if
//   Bundles the command, response and Wishbone signals of wb_cmd_master.
//   Signal names keep their block-level direction suffixes so waveforms
//   match the datasheet. The suffixes are as seen from the master.
//   master : view used by wb_cmd_master itself.
//   slave  : view used by whatever sits around it (command source, response
//            sink and Wishbone responder).
//   Ports:
//     req_*  command valid/ready channel (we, adr, dat, sel)
//     rsp_*  response valid/ready channel (dat, err)
//     wb_*   Wishbone classic initiator signals
interface wb_cmd_master_if #(
  parameter int dw = 32,
  parameter int aw = 8
);
  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_we_i;
  logic [aw-1:0] req_adr_i;
  logic [dw-1:0] req_dat_i;
  logic [3:0]    req_sel_i;

  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [dw-1:0] rsp_dat_o;
  logic          rsp_err_o;

  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [aw-1:0] wb_adr_o;
  logic [dw-1:0] wb_dat_o;
  logic [3:0]    wb_sel_o;
  logic [dw-1:0] wb_dat_i;
  logic          wb_ack_i;
  logic          wb_err_i;

  modport master (
    input  req_valid_i, req_we_i, req_adr_i, req_dat_i, req_sel_i,
    output req_ready_o,
    output rsp_valid_o, rsp_dat_o, rsp_err_o,
    input  rsp_ready_i,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    output req_valid_i, req_we_i, req_adr_i, req_dat_i, req_sel_i,
    input  req_ready_o,
    input  rsp_valid_o, rsp_dat_o, rsp_err_o,
    output rsp_ready_i,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/wb_cmd_master.sv
// wb_cmd_master
//   Wishbone classic initiator. It takes one read or write command at a time
//   from a valid/ready channel, runs a single Wishbone bus cycle, and returns
//   the read data and status on a valid/ready response channel.
//   FSM: IDLE (accept) -> BUS (cyc/stb high) -> RESP (hold response).
//   Optional bus-cycle timeout is built when WB_CMD_MASTER_TIMEOUT_EN is
//   defined. The strobe then stays high for at most TIMEOUT cycles before the
//   cycle is aborted with an error response.
//   Ports:
//     wb_clk_i   clock
//     wb_rst_ni  asynchronous active-low reset
//     bus        wb_cmd_master_if.master (req_*, rsp_*, wb_* signals)
//     busy_o     high whenever the FSM is not in IDLE
//   Parameters: dw (32 only), aw (address width), TIMEOUT (>= 1).
module wb_cmd_master #(
  parameter int dw      = 32,
  parameter int aw      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  wb_cmd_master_if.master bus,
  output logic            busy_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_e;

  typedef struct packed {
    logic          we;
    logic [aw-1:0] adr;
    logic [dw-1:0] dat;
    logic [3:0]    sel;
  } cmd_t;

  typedef struct packed {
    logic          err;
    logic [dw-1:0] dat;
  } rsp_t;

  state_e state_q, state_d;
  cmd_t   cmd_q, cmd_d;
  rsp_t   rsp_q, rsp_d;
  logic   abort;

  // A TIMEOUT below 1 is meaningless. Only the timeout build looks at it.
  if (TIMEOUT < 1) begin : g_timeout_illegal
  end

`ifdef WB_CMD_MASTER_TIMEOUT_EN
  localparam int            TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt_q;

  // The counter is held at zero outside BUS, so it starts from zero on every
  // BUS entry. It counts BUS cycles that have no ack and no err.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)                            cnt_q <= '0;
    else if (state_q != BUS)                   cnt_q <= '0;
    else if (!bus.wb_ack_i && !bus.wb_err_i)   cnt_q <= cnt_q + TW'(1);
  end

  // This is the last permitted strobe cycle. Ack/err still win in the FSM.
  assign abort = (cnt_q == TO_LAST);
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    rsp_d   = rsp_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          cmd_d.we  = bus.req_we_i;
          cmd_d.adr = bus.req_adr_i;
          cmd_d.dat = bus.req_dat_i;
          cmd_d.sel = bus.req_sel_i;
          state_d   = BUS;
        end
      end
      BUS: begin
        // Priority is err, then ack, then timeout. Read data is returned
        // only for an acked read.
        if (bus.wb_err_i) begin
          rsp_d.err = 1'b1;
          rsp_d.dat = '0;
          state_d   = RESP;
        end else if (bus.wb_ack_i) begin
          rsp_d.err = 1'b0;
          rsp_d.dat = cmd_q.we ? '0 : bus.wb_dat_i;
          state_d   = RESP;
        end else if (abort) begin
          rsp_d.err = 1'b1;
          rsp_d.dat = '0;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      rsp_q   <= rsp_d;
    end
  end

  // cyc/stb are decoded from the state register. The async reset clears the
  // state, so cyc/stb drop at the moment reset is asserted.
  assign bus.wb_cyc_o    = (state_q == BUS);
  assign bus.wb_stb_o    = (state_q == BUS);
  // Address, data and control keep their last values between cycles.
  assign bus.wb_we_o     = cmd_q.we;
  assign bus.wb_adr_o    = cmd_q.adr;
  assign bus.wb_dat_o    = cmd_q.dat;
  assign bus.wb_sel_o    = cmd_q.sel;

  assign bus.req_ready_o = (state_q == IDLE);
  assign bus.rsp_valid_o = (state_q == RESP);
  assign bus.rsp_dat_o   = rsp_q.dat;
  assign bus.rsp_err_o   = rsp_q.err;
  assign busy_o          = (state_q != IDLE);

endmodule
